// File: rtl/watch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | watch_pkg                                                            |
// | Shared states, field limits and field encodings for the watch setter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    localparam logic [2:0] FLD_HOUR = 3'b100;
    localparam logic [2:0] FLD_MIN  = 3'b010;
    localparam logic [2:0] FLD_SEC  = 3'b001;

    function automatic logic [5:0] clamp_field(input logic [5:0] val, input logic [5:0] max);
        return (val > max) ? max : val;
    endfunction

    // Single-field step with wrap; no carry into neighbouring fields.
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                             input logic up);
        if (up)
            return (val >= max) ? 6'd0 : val + 6'd1;
        else
            return (val == 6'd0 || val > max) ? max : val - 6'd1;
    endfunction

    function automatic logic [2:0] field_of(input state_t s);
        case (s)
            SET_HOUR: return FLD_HOUR;
            SET_MIN:  return FLD_MIN;
            SET_SEC:  return FLD_SEC;
            default:  return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_repeat                                                           |
// | Edge step plus hold-to-auto-repeat for one step button               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module btn_repeat #(
    parameter int HOLD_DLY      = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic enable,
    input  logic restart,
    output logic step
);

    localparam int MAXC = (HOLD_DLY > REPEAT_PERIOD) ? HOLD_DLY : REPEAT_PERIOD;
    localparam int CW   = $clog2(MAXC + 1);

    logic          r_btn_q;
    logic          r_rep;
    logic [CW-1:0] r_cnt;
    logic          w_rise;
    logic          w_timeout;
    logic [CW-1:0] w_limit;

    assign w_rise    = btn & ~r_btn_q;
    assign w_limit   = r_rep ? CW'(REPEAT_PERIOD - 1) : CW'(HOLD_DLY - 1);
    assign w_timeout = btn & r_btn_q & (r_cnt == w_limit);
    assign step      = enable & ~restart & (w_rise | w_timeout);

    // r_cnt counts cycles since the last step (or since a restart).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b0;
            r_rep   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_btn_q <= btn;
            if (!enable || restart || !btn || w_rise) begin
                r_rep <= 1'b0;
                r_cnt <= '0;
            end else if (w_timeout) begin
                r_rep <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/watch_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | watch_set_ctrl                                                       |
// | Time-setting controller: capture, field edit, auto-repeat, reload    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int HOLD_DLY      = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int BLINK_PERIOD  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    output logic       o_run_en,
    output logic       o_load,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic [2:0] o_field,
    output logic       o_blink
);

    localparam int BW = $clog2(BLINK_PERIOD + 1);

    state_t        r_state, w_state_nxt;
    logic          r_mode_q, r_next_q;
    logic [BW-1:0] r_blink_cnt;
    logic          w_mode_rise, w_next_rise;
    logic          w_in_set, w_capture, w_load_nxt, w_field_chg, w_rep_en;
    logic          w_up_step, w_dn_step, w_step, w_step_up;

    assign w_mode_rise = btn_mode & ~r_mode_q;
    assign w_next_rise = btn_next & ~r_next_q;
    assign w_in_set    = (r_state != RUN);
    assign w_field_chg = w_in_set & ~w_mode_rise & w_next_rise;
    assign w_rep_en    = w_in_set & ~w_mode_rise & ~(btn_up & btn_down);
    assign w_step      = w_up_step | w_dn_step;
    assign w_step_up   = w_up_step;

    btn_repeat #(.HOLD_DLY(HOLD_DLY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
        .clk(clk), .rst(rst), .btn(btn_up), .enable(w_rep_en),
        .restart(w_next_rise), .step(w_up_step)
    );

    btn_repeat #(.HOLD_DLY(HOLD_DLY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dn (
        .clk(clk), .rst(rst), .btn(btn_down), .enable(w_rep_en),
        .restart(w_next_rise), .step(w_dn_step)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Mode outranks next; both outrank up/down (gated via w_rep_en and restart).
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load_nxt  = 1'b0;
        case (r_state)
            RUN: if (w_mode_rise) begin
                w_state_nxt = SET_HOUR;
                w_capture   = 1'b1;
            end
            SET_HOUR: if (w_mode_rise) begin
                w_state_nxt = RUN;
                w_load_nxt  = 1'b1;
            end else if (w_next_rise) w_state_nxt = SET_MIN;
            SET_MIN: if (w_mode_rise) begin
                w_state_nxt = RUN;
                w_load_nxt  = 1'b1;
            end else if (w_next_rise) w_state_nxt = SET_SEC;
            SET_SEC: if (w_mode_rise) begin
                w_state_nxt = RUN;
                w_load_nxt  = 1'b1;
            end else if (w_next_rise) w_state_nxt = SET_HOUR;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q    <= 1'b0;
            r_next_q    <= 1'b0;
            o_run_en    <= 1'b1;
            o_load      <= 1'b0;
            o_field     <= 3'b000;
            o_hour      <= 5'd0;
            o_min       <= 6'd0;
            o_sec       <= 6'd0;
            o_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            r_mode_q <= btn_mode;
            r_next_q <= btn_next;
            o_run_en <= (w_state_nxt == RUN);
            o_load   <= w_load_nxt;
            o_field  <= field_of(w_state_nxt);

            if (w_capture) begin
                o_hour <= 5'(clamp_field({1'b0, i_hour}, HOUR_MAX));
                o_min  <= clamp_field(i_min, MIN_MAX);
                o_sec  <= clamp_field(i_sec, SEC_MAX);
            end else if (w_step) begin
                case (r_state)
                    SET_HOUR: o_hour <= 5'(wrap_step({1'b0, o_hour}, HOUR_MAX, w_step_up));
                    SET_MIN:  o_min  <= wrap_step(o_min, MIN_MAX, w_step_up);
                    SET_SEC:  o_sec  <= wrap_step(o_sec, SEC_MAX, w_step_up);
                    default:  ;
                endcase
            end

            // Keep the field solidly visible whenever the user touches it.
            if (w_state_nxt == RUN || w_capture || w_field_chg || w_step) begin
                o_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BW'(BLINK_PERIOD - 1)) begin
                o_blink     <= ~o_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

endmodule
`default_nettype wire
